clint_timer: RTL and testbench

- Memory-mapped timer/software-interrupt responder on the CPU data bus.
- Slave end of the CPU's load/store port, which is address, write enable, read enable, write data and read data. It is the source that drives the CPU's timer_interrupt and software_interrupt inputs.
- Holds a 64-bit free-running mtime, a 64-bit mtimecmp and a 1-bit msip.
- The top level muxes bus_rd_data into the CPU read path whenever bus_sel is high.

---
 rtl/clint_timer_if.sv | 19 +
 rtl/clint_timer.sv | 122 ++++++++++++
 tb/tb_clint_timer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/clint_timer_if.sv
// rtl/clint_timer_if.sv - CPU load/store port as seen by the CLINT timer block.
interface clint_timer_if;
  logic [31:0] bus_addr;
  logic        bus_wr_en;
  logic        bus_rd_en;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_sel;

  modport master (
    output bus_addr, bus_wr_en, bus_rd_en, bus_wr_data,
    input  bus_rd_data, bus_sel
  );

  modport slave (
    input  bus_addr, bus_wr_en, bus_rd_en, bus_wr_data,
    output bus_rd_data, bus_sel
  );
endinterface

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - mtime/mtimecmp/msip responder driving timer and software interrupts.
// Optional CLINT_HI_LATCH_EN: MTIME_LO reads latch mtime[63:32] for an atomic LO-then-HI read.
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  clint_timer_if.slave  cpu,
  output logic          timer_interrupt,
  output logic          software_interrupt
);

  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;
  localparam logic [15:0] BASE_HI     = BASE_ADDR[31:16];
  localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] prescaler_q, prescaler_d;
  logic        msip_q, msip_d;
  logic        timer_irq_q, timer_irq_d;
  logic        sw_irq_q, sw_irq_d;
`ifdef CLINT_HI_LATCH_EN
  logic [31:0] shadow_q, shadow_d;
`endif

  logic [15:0] offset;
  logic        sel;
  logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
  logic        tick;
  logic [31:0] rd_data;

  // Misaligned addresses never equal a register offset, so they fall into holes naturally.
  always_comb begin
    offset      = cpu.bus_addr[15:0];
    sel         = (cpu.bus_addr[31:16] == BASE_HI);
    hit_msip    = sel && (offset == OFF_MSIP);
    hit_cmp_lo  = sel && (offset == OFF_CMP_LO);
    hit_cmp_hi  = sel && (offset == OFF_CMP_HI);
    hit_time_lo = sel && (offset == OFF_TIME_LO);
    hit_time_hi = sel && (offset == OFF_TIME_HI);
  end

  always_comb begin
    rd_data = 32'h0;
    if (cpu.bus_rd_en) begin
      if (hit_msip)         rd_data = {31'b0, msip_q};
      else if (hit_cmp_lo)  rd_data = mtimecmp_q[31:0];
      else if (hit_cmp_hi)  rd_data = mtimecmp_q[63:32];
      else if (hit_time_lo) rd_data = mtime_q[31:0];
`ifdef CLINT_HI_LATCH_EN
      else if (hit_time_hi) rd_data = shadow_q;
`else
      else if (hit_time_hi) rd_data = mtime_q[63:32];
`endif
    end
  end

  assign cpu.bus_rd_data    = rd_data;
  assign cpu.bus_sel        = sel;
  assign timer_interrupt    = timer_irq_q;
  assign software_interrupt = sw_irq_q;

  always_comb begin
    tick        = (prescaler_q == TICK_LAST);
    prescaler_d = tick ? 16'h0 : prescaler_q + 16'h1;

    // A write to one mtime half beats the increment for that half; no carry crosses halves.
    mtime_d = mtime_q + 64'(tick);
    if (cpu.bus_wr_en && hit_time_lo)
      mtime_d = {mtime_q[63:32], cpu.bus_wr_data};
    else if (cpu.bus_wr_en && hit_time_hi)
      mtime_d = {cpu.bus_wr_data, mtime_q[31:0] + 32'(tick)};

    mtimecmp_d = mtimecmp_q;
    if (cpu.bus_wr_en && hit_cmp_lo) mtimecmp_d[31:0]  = cpu.bus_wr_data;
    if (cpu.bus_wr_en && hit_cmp_hi) mtimecmp_d[63:32] = cpu.bus_wr_data;

    msip_d = msip_q;
    if (cpu.bus_wr_en && hit_msip) msip_d = cpu.bus_wr_data[0];

    timer_irq_d = (mtime_q >= mtimecmp_q);
    sw_irq_d    = msip_q;
  end

`ifdef CLINT_HI_LATCH_EN
  always_comb begin
    shadow_d = shadow_q;
    if (cpu.bus_rd_en && hit_time_lo) shadow_d = mtime_q[63:32];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q     <= 64'h0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      prescaler_q <= 16'h0;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      sw_irq_q    <= 1'b0;
`ifdef CLINT_HI_LATCH_EN
      shadow_q    <= 32'h0;
`endif
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      prescaler_q <= prescaler_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      sw_irq_q    <= sw_irq_d;
`ifdef CLINT_HI_LATCH_EN
      shadow_q    <= shadow_d;
`endif
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - directed-vector bench for clint_timer (TICK_DIV=1 and TICK_DIV=4 instances).
module tb_clint_timer;

  localparam logic [31:0] A_MSIP    = 32'h0200_0000;
  localparam logic [31:0] A_CMP_LO  = 32'h0200_4000;
  localparam logic [31:0] A_CMP_HI  = 32'h0200_4004;
  localparam logic [31:0] A_TIME_LO = 32'h0200_BFF8;
  localparam logic [31:0] A_TIME_HI = 32'h0200_BFFC;

  logic clk = 1'b0;
  logic rst_n, rst4_n;
  logic ti1, si1, ti4, si4;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  clint_timer_if bus1 ();
  clint_timer_if bus4 ();

  clint_timer #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu(bus1),
    .timer_interrupt(ti1), .software_interrupt(si1)
  );

  clint_timer #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .cpu(bus4),
    .timer_interrupt(ti4), .software_interrupt(si4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit u, input logic [31:0] a, input logic we, input logic re,
                       input logic [31:0] d);
    if (u) begin
      bus4.bus_addr = a; bus4.bus_wr_en = we; bus4.bus_rd_en = re; bus4.bus_wr_data = d;
    end else begin
      bus1.bus_addr = a; bus1.bus_wr_en = we; bus1.bus_rd_en = re; bus1.bus_wr_data = d;
    end
  endtask

  function automatic logic [31:0] rdata(input bit u);
    return u ? bus4.bus_rd_data : bus1.bus_rd_data;
  endfunction

  // Every bus task is entered at a falling edge and returns at the next one.
  task automatic wr(input bit u, input logic [31:0] a, input logic [31:0] d);
    drive(u, a, 1'b1, 1'b0, d);
    @(negedge clk);
    drive(u, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input bit u, input logic [31:0] a, input string tag, input logic [31:0] exp);
    drive(u, a, 1'b0, 1'b1, 32'h0);
    #1;
    check_eq(tag, {32'h0, rdata(u)}, {32'h0, exp});
    @(negedge clk);
    drive(u, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rst4_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    // reset state
    check_eq("rst_ti", {63'h0, ti1}, 64'h0);
    check_eq("rst_si", {63'h0, si1}, 64'h0);
    rd(1'b0, A_TIME_LO, "rst_mtime_lo", 32'h0);
    rd(1'b0, A_CMP_LO, "rst_cmp_lo", 32'hFFFF_FFFF);
    rd(1'b0, A_CMP_HI, "rst_cmp_hi", 32'hFFFF_FFFF);

    // 1: free run from reset
    rst_n = 1'b1;
    idle(10);
    rd(1'b0, A_TIME_LO, "t1_mtime_lo", 32'd10);
    rd(1'b0, A_TIME_HI, "t1_mtime_hi", 32'd0);
    check_eq("t1_ti", {63'h0, ti1}, 64'h0);
    check_eq("t1_si", {63'h0, si1}, 64'h0);
    drive(1'b0, A_TIME_LO, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("t1_rd_idle", {32'h0, bus1.bus_rd_data}, 64'h0);
    @(negedge clk);

    // 2: compare and timer interrupt
    wr(1'b0, A_CMP_HI, 32'h0);
    wr(1'b0, A_TIME_LO, 32'd10);
    wr(1'b0, A_CMP_LO, 32'd20);
    idle(8);
    check_eq("t2_ti_at19", {63'h0, ti1}, 64'h0);
    rd(1'b0, A_TIME_LO, "t2_mtime19", 32'd19);
    check_eq("t2_ti_at20", {63'h0, ti1}, 64'h0);
    idle(1);
    check_eq("t2_ti_rise", {63'h0, ti1}, 64'h1);
    idle(3);
    check_eq("t2_ti_hold", {63'h0, ti1}, 64'h1);
    wr(1'b0, A_CMP_HI, 32'h1);
    check_eq("t2_ti_lag", {63'h0, ti1}, 64'h1);
    idle(1);
    check_eq("t2_ti_fall", {63'h0, ti1}, 64'h0);

    // 3: msip and software interrupt
    wr(1'b0, A_MSIP, 32'hFFFF_FFFF);
    check_eq("t3_si_lag", {63'h0, si1}, 64'h0);
    rd(1'b0, A_MSIP, "t3_msip1", 32'h1);
    check_eq("t3_si_rise", {63'h0, si1}, 64'h1);
    wr(1'b0, A_MSIP, 32'h0);
    check_eq("t3_si_lag0", {63'h0, si1}, 64'h1);
    idle(1);
    check_eq("t3_si_fall", {63'h0, si1}, 64'h0);
    drive(1'b0, A_MSIP, 1'b1, 1'b1, 32'h1);
    #1;
    check_eq("t3_rw_prewrite", {32'h0, bus1.bus_rd_data}, 64'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rd(1'b0, A_MSIP, "t3_rw_written", 32'h1);
    wr(1'b0, A_MSIP, 32'h0);

    // 4: mtime carry and write/increment collisions
    wr(1'b0, A_TIME_HI, 32'h0);
    wr(1'b0, A_TIME_LO, 32'hFFFF_FFFE);
    idle(2);
    rd(1'b0, A_TIME_LO, "t4_carry_lo", 32'h0);
    rd(1'b0, A_TIME_HI, "t4_carry_hi", 32'h1);
    wr(1'b0, A_TIME_LO, 32'h1234);
    rd(1'b0, A_TIME_LO, "t4_wlo_lo", 32'h1234);
    rd(1'b0, A_TIME_HI, "t4_wlo_hi", 32'h1);
    wr(1'b0, A_TIME_LO, 32'hFFFF_FFFF);
    wr(1'b0, A_TIME_HI, 32'h7);
    rd(1'b0, A_TIME_LO, "t4_whi_lo", 32'h0);
    rd(1'b0, A_TIME_HI, "t4_whi_nocarry", 32'h7);
    wr(1'b0, A_TIME_HI, 32'hFFFF_FFFF);
    wr(1'b0, A_TIME_LO, 32'hFFFF_FFFF);
    idle(1);
    rd(1'b0, A_TIME_LO, "t4_wrap_lo", 32'h0);
    rd(1'b0, A_TIME_HI, "t4_wrap_hi", 32'h0);

    // high-word read after LO read across a carry
    wr(1'b0, A_TIME_HI, 32'h0);
    wr(1'b0, A_TIME_LO, 32'hFFFF_FFFF);
    rd(1'b0, A_TIME_LO, "t6_latch_lo", 32'hFFFF_FFFF);
`ifdef CLINT_HI_LATCH_EN
    rd(1'b0, A_TIME_HI, "t6_latch_hi", 32'h0);
`else
    rd(1'b0, A_TIME_HI, "t6_live_hi", 32'h1);
`endif

    // 6: holes and window decode
    drive(1'b0, 32'h0200_0008, 1'b1, 1'b0, 32'h5);
    #1;
    check_eq("t6_sel_hole", {63'h0, bus1.bus_sel}, 64'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rd(1'b0, 32'h0200_0008, "t6_hole_rd", 32'h0);
    rd(1'b0, A_MSIP, "t6_hole_msip", 32'h0);
    wr(1'b0, 32'h0200_4001, 32'hAA);
    rd(1'b0, A_CMP_LO, "t6_misalign_cmp", 32'd20);
    rd(1'b0, 32'h0200_4001, "t6_misalign_rd", 32'h0);
    drive(1'b0, 32'h0300_0000, 1'b0, 1'b1, 32'h0);
    #1;
    check_eq("t6_sel_out", {63'h0, bus1.bus_sel}, 64'h0);
    check_eq("t6_rd_out", {32'h0, bus1.bus_rd_data}, 64'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    wr(1'b0, 32'h0300_0000, 32'h1);
    rd(1'b0, A_MSIP, "t6_out_msip", 32'h0);

    // 5: prescaler with TICK_DIV=4
    rst4_n = 1'b1;
    idle(3);
    rd(1'b1, A_TIME_LO, "t5_k3", 32'd0);
    rd(1'b1, A_TIME_LO, "t5_k4", 32'd1);
    idle(3);
    rd(1'b1, A_TIME_LO, "t5_k8", 32'd2);
    wr(1'b1, A_TIME_LO, 32'd100);
    rd(1'b1, A_TIME_LO, "t5_w100_a", 32'd100);
    rd(1'b1, A_TIME_LO, "t5_w100_b", 32'd100);
    rd(1'b1, A_TIME_LO, "t5_phase", 32'd101);

    // asynchronous reset mid-operation
    wr(1'b0, A_CMP_HI, 32'h0);
    wr(1'b0, A_CMP_LO, 32'h0);
    wr(1'b0, A_MSIP, 32'h1);
    idle(1);
    check_eq("ar_ti_before", {63'h0, ti1}, 64'h1);
    check_eq("ar_si_before", {63'h0, si1}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_ti", {63'h0, ti1}, 64'h0);
    check_eq("ar_si", {63'h0, si1}, 64'h0);
    drive(1'b0, A_CMP_HI, 1'b0, 1'b1, 32'h0);
    #1;
    check_eq("ar_cmp_hi", {32'h0, bus1.bus_rd_data}, 64'hFFFF_FFFF);
    drive(1'b0, A_MSIP, 1'b0, 1'b1, 32'h0);
    #1;
    check_eq("ar_msip", {32'h0, bus1.bus_rd_data}, 64'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
